// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared types and helpers for the load/store unit:
//   - lsu_state_e      : bus-handshake FSM states (IDLE, WAIT, DONE)
//   - F3_*             : funct3 encodings for access size and signedness
//   - lsu_access_legal : funct3/alignment legality check for one core request
// -----------------------------------------------------------------------------
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // True when the request may go to the bus: a defined funct3 for the
  // direction (unsigned variants exist only for loads) and natural alignment.
  function automatic logic lsu_access_legal(input logic       is_store,
                                            input logic [2:0] funct3,
                                            input logic [1:0] addr_lo);
    logic legal;
    case (funct3)
      F3_B:    legal = 1'b1;
      F3_BU:   legal = !is_store;
      F3_H:    legal = !addr_lo[0];
      F3_HU:   legal = !is_store && !addr_lo[0];
      F3_W:    legal = (addr_lo == 2'b00);
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// -----------------------------------------------------------------------------
// lsu_load_align
// Purely combinational lane extraction and sign/zero extension of a loaded
// memory word.
// Ports:
//   word_i    in  32  raw word returned by the data memory
//   addr_lo_i in  2   byte offset of the access within the word
//   funct3_i  in  3   access size/sign encoding (F3_*)
//   data_o    out 32  extended load value
// -----------------------------------------------------------------------------
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Shifting the addressed lane down to bit 0 serves bytes and halves alike;
  // legal halfword offsets are only 0 or 2, so bits [15:0] hold the halfword.
  always_comb begin
    shifted  = word_i >> {addr_lo_i, 3'b000};
    byte_sel = shifted[7:0];
    half_sel = shifted[15:0];
    case (funct3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data_o = {24'h000000, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data_o = {16'h0000, half_sel};
      F3_W:    data_o = word_i;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_interface.sv
// -----------------------------------------------------------------------------
// lsu_mem_interface
// Load/store unit bridging a single-cycle core request to a req/ack data bus.
// The core is stalled while a transaction is outstanding; store data and byte
// enables are lane-aligned on the way out, load data is extracted and
// extended on the way back and held in a register for the writeback mux.
// Ports:
//   clk, reset         clock (rising edge), asynchronous active-high reset
//   mem_read/mem_write load/store request (store wins if both set)
//   funct3, addr,wdata access size/sign, byte address, store data
//   rdata              registered extended load data
//   stall              core must hold PC and pipeline inputs
//   misalign           one-cycle pulse for an illegal/misaligned request
//   bus_err            one-cycle pulse after an ack timeout
//   dmem_*             registered bus request side, dmem_rdata/dmem_ack return
// -----------------------------------------------------------------------------
module lsu_mem_interface
  import lsu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata,
  output logic            stall,
  output logic            misalign,
  output logic            bus_err,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ack
);

  // Holds 0..TIMEOUT_CYCLES-1; TIMEOUT_CYCLES >= 2 keeps this at least 1 bit.
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  lsu_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [3:0]      be_q, be_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [1:0]      addr_lo_q, addr_lo_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            bus_err_q, bus_err_d;

  logic            access_valid;
  logic            legal;
  logic            start;
  logic            timeout;
  logic [3:0]      st_be;
  logic [XLEN-1:0] st_wdata;
  logic [XLEN-1:0] load_val;

  assign access_valid = mem_read | mem_write;
  assign legal        = lsu_access_legal(mem_write, funct3, addr[1:0]);
  assign start        = (state_q == IDLE) && access_valid && legal;
  // Ack on the last allowed cycle beats the timeout.
  assign timeout      = (state_q == WAIT) && !dmem_ack &&
                        (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Extraction uses the latched offset/size, since the core inputs are not
  // guaranteed stable once the request has been accepted.
  lsu_load_align u_load_align (
    .word_i    (dmem_rdata),
    .addr_lo_i (addr_lo_q),
    .funct3_i  (funct3_q),
    .data_o    (load_val)
  );

  // Store lane alignment; loads always request the full word.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = wdata;
    if (mem_write) begin
      case (funct3)
        F3_B: begin
          st_be    = 4'b0001 << addr[1:0];
          st_wdata = {4{wdata[7:0]}};
        end
        F3_H: begin
          st_be    = addr[1] ? 4'b1100 : 4'b0011;
          st_wdata = {2{wdata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Registers: every flop here is reset, including the data path, because
  // all bus and result outputs must read 0 while reset is asserted.
  // NOTE: non-blocking assignments in clocked blocks so every flop samples the
  // pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      funct3_q  <= '0;
      addr_lo_q <= '0;
      rdata_q   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      funct3_q  <= funct3_d;
      addr_lo_q <= addr_lo_d;
      rdata_q   <= rdata_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Next-state logic and the WAIT-cycle counter.
  // NOTE: every variable gets a default at the top of an always_comb so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (dmem_ack || timeout) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered bus outputs.
  always_comb begin
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    funct3_d  = funct3_q;
    addr_lo_d = addr_lo_q;
    rdata_d   = rdata_q;
    bus_err_d = 1'b0;
    if (start) begin
      req_d     = 1'b1;
      we_d      = mem_write;
      addr_d    = {addr[XLEN-1:2], 2'b00};
      be_d      = st_be;
      wdata_d   = st_wdata;
      funct3_d  = funct3;
      addr_lo_d = addr[1:0];
    end else if (state_q == WAIT) begin
      if (dmem_ack) begin
        req_d = 1'b0;
        we_d  = 1'b0;
        if (!we_q) begin
          rdata_d = load_val;
        end
      end else if (timeout) begin
        req_d     = 1'b0;
        we_d      = 1'b0;
        rdata_d   = '0;
        bus_err_d = 1'b1;
      end
    end
  end

  // Core-facing handshake outputs.
  always_comb begin
    stall    = start || (state_q == WAIT);
    misalign = (state_q == IDLE) && access_valid && !legal;
  end

  assign rdata      = rdata_q;
  assign bus_err    = bus_err_q;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_mem_interface.sv
module tb_lsu_mem_interface;

  localparam int TO = 4;

  logic        clk;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        misalign;
  logic        bus_err;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  lsu_mem_interface #(.XLEN(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .stall      (stall),
    .misalign   (misalign),
    .bus_err    (bus_err),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_be    (dmem_be),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
  } bus_exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic        bus_err;
    int          stalls;
  } res_exp_t;

  bus_exp_t    bus_q[$];
  res_exp_t    res_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] model_rdata = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] lo,
                                             input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lo[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] model_be(input logic wr, input logic [2:0] f3, input logic [1:0] lo);
    if (!wr || f3 == 3'b010) return 4'b1111;
    if (f3 == 3'b001) return lo[1] ? 4'b1100 : 4'b0011;
    case (lo)
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0010;
      2'd2:    return 4'b0100;
      default: return 4'b1000;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    if (f3 == 3'b000) return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
    if (f3 == 3'b001) return {wd[15:0], wd[15:0]};
    return wd;
  endfunction

  // Called at posedge+1 with the DUT idle; returns at posedge+1 with it idle.
  // ack_at is the WAIT cycle (1-based) carrying the ack; <=0 means never.
  task automatic do_access(input string nm, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rword, input int ack_at);
    bus_exp_t be_e;
    res_exp_t rs_e;
    bus_exp_t be_o;
    res_exp_t rs_o;
    int       stalls;
    bit       done;
    mem_read  = !wr;
    mem_write = wr;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
    be_e.addr  = {a[31:2], 2'b00};
    be_e.be    = model_be(wr, f3, a[1:0]);
    be_e.wdata = model_wdata(f3, wd);
    be_e.we    = wr;
    bus_q.push_back(be_e);
    if (ack_at < 1 || ack_at > TO) begin
      rs_e.rdata   = 32'h0;
      rs_e.bus_err = 1'b1;
      rs_e.stalls  = 1 + TO;
    end else begin
      rs_e.rdata   = wr ? model_rdata : model_load(rword, a[1:0], f3);
      rs_e.bus_err = 1'b0;
      rs_e.stalls  = 1 + ack_at;
    end
    model_rdata = rs_e.rdata;
    res_q.push_back(rs_e);

    stalls = 0;
    done   = 0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (cyc == ack_at) begin
        dmem_ack   = 1'b1;
        dmem_rdata = rword;
      end
      @(negedge clk);
      if (cyc == 0) check({nm, " stall_idle"}, 32'(stall), 32'd1);
      if (cyc == 1 && bus_q.size() > 0) begin
        be_o = bus_q.pop_front();
        check({nm, " dmem_req"}, 32'(dmem_req), 32'd1);
        check({nm, " dmem_addr"}, dmem_addr, be_o.addr);
        check({nm, " dmem_be"}, 32'(dmem_be), 32'(be_o.be));
        check({nm, " dmem_we"}, 32'(dmem_we), 32'(be_o.we));
        if (be_o.we) check({nm, " dmem_wdata"}, dmem_wdata, be_o.wdata);
      end
      if (stall) stalls++;
      else done = 1;
      if (!done) begin
        @(posedge clk);
        #1;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'hA5A5_5A5A;
      end
    end
    if (!done) check({nm, " reached_done"}, 32'd0, 32'd1);
    if (bus_q.size() > 0) void'(bus_q.pop_front());
    if (res_q.size() > 0) begin
      rs_o = res_q.pop_front();
      check({nm, " stall_cycles"}, 32'(stalls), 32'(rs_o.stalls));
      check({nm, " rdata"}, rdata, rs_o.rdata);
      check({nm, " bus_err"}, 32'(bus_err), 32'(rs_o.bus_err));
      check({nm, " req_done"}, 32'(dmem_req), 32'd0);
    end
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    check({nm, " bus_err_clear"}, 32'(bus_err), 32'd0);
    check({nm, " stall_after"}, 32'(stall), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_illegal(input string nm, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a);
    mem_read  = !wr;
    mem_write = wr;
    funct3    = f3;
    addr      = a;
    wdata     = 32'h1122_3344;
    @(negedge clk);
    check({nm, " misalign"}, 32'(misalign), 32'd1);
    check({nm, " stall"}, 32'(stall), 32'd0);
    check({nm, " req"}, 32'(dmem_req), 32'd0);
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    check({nm, " misalign_end"}, 32'(misalign), 32'd0);
    check({nm, " req_after"}, 32'(dmem_req), 32'd0);
    check({nm, " rdata_kept"}, rdata, model_rdata);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset      = 1'b1;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    funct3     = 3'b000;
    addr       = '0;
    wdata      = '0;
    dmem_rdata = '0;
    dmem_ack   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst rdata", rdata, 32'h0);
    check("rst dmem_req", 32'(dmem_req), 32'd0);
    check("rst dmem_we", 32'(dmem_we), 32'd0);
    check("rst dmem_addr", dmem_addr, 32'h0);
    check("rst dmem_be", 32'(dmem_be), 32'd0);
    check("rst dmem_wdata", dmem_wdata, 32'h0);
    check("rst stall", 32'(stall), 32'd0);
    check("rst misalign", 32'(misalign), 32'd0);
    check("rst bus_err", 32'(bus_err), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    do_access("lw100",  1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 1);
    do_access("lb103",  1'b0, 3'b000, 32'h103, 32'h0, 32'h8011_2233, 1);
    do_access("lbu103", 1'b0, 3'b100, 32'h103, 32'h0, 32'h8011_2233, 2);
    do_access("sh202",  1'b1, 3'b001, 32'h202, 32'h0000_ABCD, 32'h0, 1);
    do_access("sb301",  1'b1, 3'b000, 32'h301, 32'h1234_5678, 32'h0, 3);
    do_access("lh102",  1'b0, 3'b001, 32'h102, 32'h0, 32'h8001_7FFF, 1);
    do_access("lhu102", 1'b0, 3'b101, 32'h102, 32'h0, 32'h8001_7FFF, 2);
    do_access("sw10c",  1'b1, 3'b010, 32'h10C, 32'hCAFE_F00D, 32'h0, 1);
    do_access("lb100",  1'b0, 3'b000, 32'h100, 32'h0, 32'h0000_007F, 1);

    do_illegal("ill_lw101",  1'b0, 3'b010, 32'h101);
    do_illegal("ill_f3_011", 1'b0, 3'b011, 32'h100);
    do_illegal("ill_sh201",  1'b1, 3'b001, 32'h201);
    do_illegal("ill_st_f3_100", 1'b1, 3'b100, 32'h100);

    // A stray ack while idle must not start or complete anything.
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("idle_ack req", 32'(dmem_req), 32'd0);
    check("idle_ack stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    check("idle_ack rdata", rdata, model_rdata);
    @(posedge clk);
    #1;

    do_access("lw_timeout", 1'b0, 3'b010, 32'h400, 32'h0, 32'h1111_2222, -1);
    do_access("lw_ack_last", 1'b0, 3'b010, 32'h404, 32'h0, 32'h1357_2468, TO);

    // Asynchronous reset in the middle of a WAIT.
    mem_read = 1'b1;
    funct3   = 3'b010;
    addr     = 32'h40;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rstwait req_before", 32'(dmem_req), 32'd1);
    #2;
    reset    = 1'b1;
    mem_read = 1'b0;
    #1;
    check("rstwait req_async", 32'(dmem_req), 32'd0);
    check("rstwait stall", 32'(stall), 32'd0);
    check("rstwait rdata", rdata, 32'h0);
    model_rdata = 32'h0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    do_access("lw_after_rst", 1'b0, 3'b010, 32'h500, 32'h0, 32'h0BAD_C0DE, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
